buscaminas_tablero: RTL and testbench

Parametrised Minesweeper board controller, the next generation of the fixed 4-bomb game core. It holds a ROWS×COLS board with a four-direction cursor and LFSR-based bomb placement, and handles reveal and flag actions. It also detects win and loss. It sits between the debounced push-button/switch front end and the seven-segment/VGA display logic.

---
 rtl/buscaminas_pkg.sv | 41 ++++
 rtl/buscaminas_tablero_if.sv | 46 ++++
 rtl/buscaminas_lfsr.sv | 23 ++
 rtl/buscaminas_tablero.sv | 218 +++++++++++++++++++++
 tb/tb_buscaminas_tablero.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the Minesweeper board controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package buscaminas_pkg;

  typedef enum logic [2:0] {
    INACTIVO = 3'd0,
    COLOCAR  = 3'd1,
    JUGAR    = 3'd2,
    GANADO   = 3'd3,
    PERDIDO  = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    OCULTA   = 2'd0,
    BANDERA  = 2'd1,
    REVELADA = 2'd2
  } celda_t;

  // Rising-edge pulses from the front end, in priority order (inicio highest).
  typedef struct packed {
    logic inicio;
    logic bomba;
    logic bandera;
    logic up;
    logic down;
    logic left;
    logic right;
  } botones_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clamp_bombas(input int solicitadas, input int max_bombas);
    if (solicitadas < 1) return 1;
    if (solicitadas > max_bombas) return max_bombas;
    return solicitadas;
  endfunction

endpackage

// File: rtl/buscaminas_tablero_if.sv
// Button/switch inputs and board-status outputs of the Minesweeper board controller.
// Latency: n/a (wiring only).
// Backpressure: none; inputs are level signals sampled every cycle.
interface buscaminas_tablero_if #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int MAX_BOMBS = 15
);
  import buscaminas_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(MAX_BOMBS + 1);

  logic                   inicio;
  logic [BW-1:0]          switches_bombas;
  logic                   button_up;
  logic                   button_down;
  logic                   button_left;
  logic                   button_right;
  logic                   button_bomba;
  logic                   button_bandera;

  logic [RW-1:0]          cursor_row;
  logic [CW-1:0]          cursor_col;
  celda_t                 celda_estado;
  logic [3:0]             vecinos;
  logic signed [BW:0]     banderas_restantes;
  estado_t                estado;
  logic [ROWS*COLS-1:0]   mapa_bombas;

  modport master (
    output inicio, switches_bombas, button_up, button_down, button_left,
           button_right, button_bomba, button_bandera,
    input  cursor_row, cursor_col, celda_estado, vecinos, banderas_restantes,
           estado, mapa_bombas
  );

  modport slave (
    input  inicio, switches_bombas, button_up, button_down, button_left,
           button_right, button_bomba, button_bandera,
    output cursor_row, cursor_col, celda_estado, vecinos, banderas_restantes,
           estado, mapa_bombas
  );

endinterface

// File: rtl/buscaminas_lfsr.sv
// 16-bit Fibonacci LFSR used as the bomb-placement random source.
// Latency: one step per enabled cycle; q shows the current register.
// Backpressure: en holds the sequence.
module buscaminas_lfsr
  import buscaminas_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/buscaminas_tablero.sv
// Minesweeper board: cursor, LFSR bomb placement, reveal/flag, win/loss. Define BUSCAMINAS_WRAP_EN to wrap the cursor at edges.
// Latency: a button rising edge in cycle n takes effect at the clock edge ending cycle n+1.
// Backpressure: none; edges outside JUGAR (and inicio during COLOCAR) are dropped.
module buscaminas_tablero
  import buscaminas_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int MAX_BOMBS = 15
) (
  input logic                 clk,
  input logic                 rst,
  buscaminas_tablero_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(MAX_BOMBS + 1);
  localparam int VW = $clog2(N + 1);
  localparam logic signed [BW:0] UNO = (BW+1)'(1);

  botones_t           btn_raw, btn_prev, btn_edge;
  estado_t            estado_q, estado_d;
  celda_t             celdas_q [N];
  logic [N-1:0]       mapa_q;
  logic [RW-1:0]      cursor_r, row_d;
  logic [CW-1:0]      cursor_c, col_d;
  logic [BW-1:0]      nb_q, colocadas_q;
  logic [VW-1:0]      reveladas_q;
  logic signed [BW:0] banderas_q;
  logic [15:0]        lfsr_q;
  logic [IW-1:0]      cur_idx, lfsr_idx;
  celda_t             celda_cur;
  logic               bomba_cur, place_ok, ultima_segura, unused_lfsr;
  logic               do_clear, do_place, load_banderas, do_reveal, do_flag, do_move;
  logic [3:0]         vec_cnt;
  int                 vr, vc;

  buscaminas_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  assign btn_raw = '{inicio:  bus.inicio,
                     bomba:   bus.button_bomba,
                     bandera: bus.button_bandera,
                     up:      bus.button_up,
                     down:    bus.button_down,
                     left:    bus.button_left,
                     right:   bus.button_right};

  // The edge pulse is registered so every action lands one cycle after detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prev <= '0;
      btn_edge <= '0;
    end else begin
      btn_prev <= btn_raw;
      btn_edge <= btn_raw & ~btn_prev;
    end
  end

  assign cur_idx       = IW'(int'(cursor_r) * COLS + int'(cursor_c));
  assign celda_cur     = celdas_q[cur_idx];
  assign bomba_cur     = mapa_q[cur_idx];
  assign lfsr_idx      = lfsr_q[IW-1:0];
  assign unused_lfsr   = ^lfsr_q[15:IW];
  assign place_ok      = (int'(lfsr_idx) < N) && !mapa_q[lfsr_idx];
  assign ultima_segura = (int'(reveladas_q) + 1) == (N - int'(nb_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado_q <= INACTIVO;
    else      estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INACTIVO, GANADO, PERDIDO: if (btn_edge.inicio) estado_d = COLOCAR;
      COLOCAR: if (colocadas_q == nb_q) estado_d = JUGAR;
      JUGAR: begin
        if (btn_edge.inicio) begin
          estado_d = COLOCAR;
        end else if (btn_edge.bomba && celda_cur == OCULTA) begin
          if (bomba_cur)          estado_d = PERDIDO;
          else if (ultima_segura) estado_d = GANADO;
        end
      end
      default: estado_d = INACTIVO;
    endcase
  end

  always_comb begin
    do_clear      = 1'b0;
    do_place      = 1'b0;
    load_banderas = 1'b0;
    do_reveal     = 1'b0;
    do_flag       = 1'b0;
    do_move       = 1'b0;
    case (estado_q)
      INACTIVO, GANADO, PERDIDO: do_clear = btn_edge.inicio;
      COLOCAR: begin
        do_place      = (colocadas_q != nb_q);
        load_banderas = (colocadas_q == nb_q);
      end
      JUGAR: begin
        if (btn_edge.inicio)       do_clear  = 1'b1;
        else if (btn_edge.bomba)   do_reveal = (celda_cur == OCULTA);
        else if (btn_edge.bandera) do_flag   = (celda_cur != REVELADA);
        else                       do_move   = 1'b1;
      end
      default: ;
    endcase
  end

  // Both axes move independently; up beats down and left beats right.
  always_comb begin
    row_d = cursor_r;
    col_d = cursor_c;
    if (btn_edge.up) begin
      if (cursor_r != '0) row_d = cursor_r - 1'b1;
`ifdef BUSCAMINAS_WRAP_EN
      else row_d = RW'(ROWS - 1);
`endif
    end else if (btn_edge.down) begin
      if (cursor_r != RW'(ROWS - 1)) row_d = cursor_r + 1'b1;
`ifdef BUSCAMINAS_WRAP_EN
      else row_d = '0;
`endif
    end
    if (btn_edge.left) begin
      if (cursor_c != '0) col_d = cursor_c - 1'b1;
`ifdef BUSCAMINAS_WRAP_EN
      else col_d = CW'(COLS - 1);
`endif
    end else if (btn_edge.right) begin
      if (cursor_c != CW'(COLS - 1)) col_d = cursor_c + 1'b1;
`ifdef BUSCAMINAS_WRAP_EN
      else col_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_r    <= '0;
      cursor_c    <= '0;
      mapa_q      <= '0;
      nb_q        <= '0;
      colocadas_q <= '0;
      reveladas_q <= '0;
      banderas_q  <= '0;
      for (int i = 0; i < N; i++) celdas_q[i] <= OCULTA;
    end else begin
      if (do_clear) begin
        cursor_r    <= '0;
        cursor_c    <= '0;
        mapa_q      <= '0;
        colocadas_q <= '0;
        reveladas_q <= '0;
        banderas_q  <= '0;
        nb_q        <= BW'(clamp_bombas(int'(bus.switches_bombas), MAX_BOMBS));
        for (int i = 0; i < N; i++) celdas_q[i] <= OCULTA;
      end
      if (do_place && place_ok) begin
        mapa_q[lfsr_idx] <= 1'b1;
        colocadas_q      <= colocadas_q + 1'b1;
      end
      if (load_banderas) banderas_q <= $signed({1'b0, nb_q});
      if (do_reveal) begin
        celdas_q[cur_idx] <= REVELADA;
        if (!bomba_cur) reveladas_q <= reveladas_q + 1'b1;
      end
      if (do_flag) begin
        if (celda_cur == OCULTA) begin
          celdas_q[cur_idx] <= BANDERA;
          banderas_q        <= banderas_q - UNO;
        end else begin
          celdas_q[cur_idx] <= OCULTA;
          banderas_q        <= banderas_q + UNO;
        end
      end
      if (do_move) begin
        cursor_r <= row_d;
        cursor_c <= col_d;
      end
    end
  end

  // Neighbour count never wraps, even when the cursor does.
  always_comb begin
    vec_cnt = '0;
    vr      = 0;
    vc      = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        vr = int'(cursor_r) + dr;
        vc = int'(cursor_c) + dc;
        if ((dr != 0 || dc != 0) && vr >= 0 && vr < ROWS && vc >= 0 && vc < COLS &&
            mapa_q[IW'(vr * COLS + vc)])
          vec_cnt = vec_cnt + 4'd1;
      end
    end
  end

  assign bus.cursor_row         = cursor_r;
  assign bus.cursor_col         = cursor_c;
  assign bus.celda_estado       = celda_cur;
  assign bus.vecinos            = (celda_cur == REVELADA) ? vec_cnt : 4'd0;
  assign bus.banderas_restantes = banderas_q;
  assign bus.estado             = estado_q;
  assign bus.mapa_bombas        = mapa_q;

endmodule

// File: tb/tb_buscaminas_tablero.sv
// Randomised bench for buscaminas_tablero: a rule-level board model feeds a scoreboard,
// and an independent monitor compares DUT outputs when each expectation falls due.
module tb_buscaminas_tablero;
  import buscaminas_pkg::*;

  localparam int ROWS = 8, COLS = 8, MAX_BOMBS = 15, N = ROWS * COLS;
  localparam logic [6:0] INI = 7'b1000000, BOMBA = 7'b0100000, BAND = 7'b0010000;
  localparam logic [6:0] UP = 7'b0001000, DOWN = 7'b0000100, LEFT = 7'b0000010, RIGHT = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buscaminas_tablero_if #(.ROWS(ROWS), .COLS(COLS), .MAX_BOMBS(MAX_BOMBS)) bus ();

  buscaminas_tablero #(.ROWS(ROWS), .COLS(COLS), .MAX_BOMBS(MAX_BOMBS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int due; int kind; int row; int col; int ecel; int vec; int band; int est; int pop;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];
  int    cyc = 0, n_checks = 0, n_fail = 0;

  estado_t m_est;
  celda_t  cel   [ROWS][COLS];
  bit      bombs [ROWS][COLS];
  int      cur_r, cur_c, band, nb, rev;

  task automatic chk(input string tag, input string fld, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", tag, fld, act, exp, cyc);
    end
  endtask

  function automatic int nvec(input int r, input int c);
    int n = 0;
    for (int i = r - 1; i <= r + 1; i++)
      for (int j = c - 1; j <= c + 1; j++)
        if ((i != r || j != c) && i >= 0 && i < ROWS && j >= 0 && j < COLS && bombs[i][j]) n++;
    return n;
  endfunction

  function automatic void model_clear();
    cur_r = 0; cur_c = 0; band = 0; rev = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cel[r][c] = OCULTA; bombs[r][c] = 1'b0;
      end
  endfunction

  function automatic void model_reset();
    model_clear();
    m_est = INACTIVO;
    nb = 0;
  endfunction

  function automatic void model_apply(input logic [6:0] m);
    if (m[6]) begin
      if (m_est != COLOCAR) begin
        nb = int'(bus.switches_bombas);
        if (nb < 1) nb = 1;
        if (nb > MAX_BOMBS) nb = MAX_BOMBS;
        model_clear();
        m_est = COLOCAR;
      end
      return;
    end
    if (m_est != JUGAR) return;
    if (m[5]) begin
      if (cel[cur_r][cur_c] == OCULTA) begin
        cel[cur_r][cur_c] = REVELADA;
        if (bombs[cur_r][cur_c]) m_est = PERDIDO;
        else begin
          rev++;
          if (rev == N - nb) m_est = GANADO;
        end
      end
      return;
    end
    if (m[4]) begin
      if (cel[cur_r][cur_c] == OCULTA) begin cel[cur_r][cur_c] = BANDERA; band--; end
      else if (cel[cur_r][cur_c] == BANDERA) begin cel[cur_r][cur_c] = OCULTA; band++; end
      return;
    end
`ifdef BUSCAMINAS_WRAP_EN
    if (m[3])      cur_r = (cur_r + ROWS - 1) % ROWS;
    else if (m[2]) cur_r = (cur_r + 1) % ROWS;
    if (m[1])      cur_c = (cur_c + COLS - 1) % COLS;
    else if (m[0]) cur_c = (cur_c + 1) % COLS;
`else
    if (m[3])      cur_r = (cur_r > 0) ? cur_r - 1 : 0;
    else if (m[2]) cur_r = (cur_r < ROWS - 1) ? cur_r + 1 : ROWS - 1;
    if (m[1])      cur_c = (cur_c > 0) ? cur_c - 1 : 0;
    else if (m[0]) cur_c = (cur_c < COLS - 1) ? cur_c + 1 : COLS - 1;
`endif
  endfunction

  function automatic void push_full(input string nm, input int dly);
    exp_t e;
    e.due  = cyc + dly; e.kind = 0; e.row = cur_r; e.col = cur_c;
    e.ecel = int'(cel[cur_r][cur_c]);
    e.vec  = (cel[cur_r][cur_c] == REVELADA) ? nvec(cur_r, cur_c) : 0;
    e.band = band; e.est = int'(m_est); e.pop = 0;
    sbq.push_back(e); nameq.push_back(nm);
  endfunction

  function automatic void push_pop(input string nm, input int dly, input int pop);
    exp_t e;
    e.due = cyc + dly; e.kind = 2; e.row = 0; e.col = 0; e.ecel = 0;
    e.vec = 0; e.band = 0; e.est = 0; e.pop = pop;
    sbq.push_back(e); nameq.push_back(nm);
  endfunction

  // Monitor: compares every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    cyc = cyc + 1;
    while (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e  = sbq.pop_front();
      nm = nameq.pop_front();
      if (e.kind == 2) begin
        chk(nm, "bomb_count", $countones(bus.mapa_bombas), e.pop);
      end else begin
        chk(nm, "row",      int'(bus.cursor_row), e.row);
        chk(nm, "col",      int'(bus.cursor_col), e.col);
        chk(nm, "celda",    int'(bus.celda_estado), e.ecel);
        chk(nm, "vecinos",  int'(bus.vecinos), e.vec);
        chk(nm, "banderas", int'(bus.banderas_restantes), e.band);
        chk(nm, "estado",   int'(bus.estado), e.est);
      end
    end
  end

  task automatic press(input logic [6:0] m, input string nm);
    @(negedge clk); #1;
    {bus.inicio, bus.button_bomba, bus.button_bandera, bus.button_up,
     bus.button_down, bus.button_left, bus.button_right} = m;
    model_apply(m);
    push_full(nm, 2);
    @(negedge clk); #1;
    {bus.inicio, bus.button_bomba, bus.button_bandera, bus.button_up,
     bus.button_down, bus.button_left, bus.button_right} = 7'b0;
  endtask

  task automatic wait_jugar(input string nm);
    bit ok = 1'b0;
    logic [N-1:0] mp;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (bus.estado == JUGAR) begin ok = 1'b1; break; end
    end
    #1;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: estado never reached JUGAR within 5000 cycles", nm);
    end else begin
      mp = bus.mapa_bombas;
      for (int i = 0; i < N; i++) begin
        bombs[i / COLS][i % COLS] = mp[0];
        mp = mp >> 1;
      end
      m_est = JUGAR;
      band  = nb;
      push_pop(nm, 1, nb);
      push_full(nm, 1);
    end
  endtask

  task automatic goto(input int r, input int c);
    for (int i = 0; i < 40 && (cur_r != r || cur_c != c); i++) begin
      if (cur_r < r)      press(DOWN, "goto");
      else if (cur_r > r) press(UP, "goto");
      else if (cur_c < c) press(RIGHT, "goto");
      else                press(LEFT, "goto");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c;
    {bus.inicio, bus.button_bomba, bus.button_bandera, bus.button_up,
     bus.button_down, bus.button_left, bus.button_right} = 7'b0;
    bus.switches_bombas = '0;
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    #1;
    push_full("reset", 1);
    push_pop("reset", 1, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    press(RIGHT, "idle_move");

    // Game A: 13 bombs, cursor/flag rules, random moves, full win.
    bus.switches_bombas = 4'd13;
    press(INI, "inicio_13");
    wait_jugar("jugar_13");
    press(DOWN, "down");
    press(RIGHT, "right");
    press(BAND, "flag_on");
    press(BOMBA, "bomba_on_flag");
    press(BAND, "flag_off");
    press(BAND | RIGHT, "flag_beats_move");
    press(BAND, "flag_restore");
    press(UP | DOWN, "up_beats_down");
    press(LEFT | RIGHT, "left_beats_right");
    press(UP, "edge_up");
    press(LEFT, "edge_left");
    for (int i = 0; i < 20; i++) press(7'($urandom_range(0, 15)), "rand_move");
    for (int i = 0; i < 3; i++) begin
      do begin
        r = $urandom_range(0, ROWS - 1);
        c = $urandom_range(0, COLS - 1);
      end while (bombs[r][c]);
      goto(r, c);
      press(BOMBA, "rand_reveal");
    end
    press(BAND, "flag_on_revealed");
    press(BOMBA, "bomba_on_revealed");
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if (!bombs[rr][cc] && cel[rr][cc] == OCULTA) begin
          goto(rr, cc);
          press(BOMBA, "reveal_all");
        end
    press(RIGHT, "move_after_win");

    // Game B: zero requested clamps to one bomb; step on it.
    bus.switches_bombas = 4'd0;
    press(INI, "inicio_0");
    wait_jugar("jugar_1");
    for (int i = 0; i < N; i++)
      if (bombs[i / COLS][i % COLS]) begin
        goto(i / COLS, i % COLS);
        press(BOMBA, "bomba_lose");
        break;
      end
    press(RIGHT, "move_after_loss");
    press(BAND, "flag_after_loss");

    // Game C: maximum bomb count, then reset in the middle of play.
    bus.switches_bombas = 4'd15;
    press(INI, "inicio_15");
    wait_jugar("jugar_15");
    press(DOWN, "down_c");
    press(RIGHT, "right_c");
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("async_rst", "estado", int'(bus.estado), int'(INACTIVO));
    chk("async_rst", "row", int'(bus.cursor_row), 0);
    chk("async_rst", "bomb_count", $countones(bus.mapa_bombas), 0);
    model_reset();
    push_full("reset_mid_game", 1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
